// File: rtl/switch_debouncer_pkg.sv
// Shared definitions for the switch debouncer: FSM state encoding and 50 MHz timing constants.
package switch_debouncer_pkg;

  typedef enum logic [1:0] {
    STABLE_LOW  = 2'd0,
    CHK_HIGH    = 2'd1,
    STABLE_HIGH = 2'd2,
    CHK_LOW     = 2'd3
  } db_state_e;

  localparam int CNT_50M       = 50_000_000;
  localparam int DEBOUNCE_20MS = CNT_50M / 50;
  localparam int HOLD_1S       = CNT_50M;

  // Bits needed to hold the values 0..n inclusive.
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/switch_debouncer_if.sv
// Event handshake bundle: one pending edge event offered by the debouncer to its consumer.
interface switch_debouncer_if #(
  parameter int WIDTH = 4
);
  logic             evt_valid;
  logic             evt_ready;
  logic [WIDTH-1:0] evt_rise;
  logic [WIDTH-1:0] evt_fall;
  logic             evt_overflow;

  modport master (
    output evt_valid, evt_rise, evt_fall, evt_overflow,
    input  evt_ready
  );

  modport slave (
    input  evt_valid, evt_rise, evt_fall, evt_overflow,
    output evt_ready
  );
endinterface

// File: rtl/switch_debouncer_chan.sv
// One switch channel: 2-FF synchroniser, debounce FSM with edge pulses and,
// when LONG_PRESS_EN is defined, a saturating hold counter for long-press detection.
module switch_debouncer_chan
  import switch_debouncer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_20MS,
  parameter int CNT_W           = 20,
  parameter int HOLD_CYCLES     = HOLD_1S
) (
  input  logic clk,
  input  logic rst,
  input  logic sw,
  output logic db,
  output logic rise,
  output logic fall,
  output logic long_press
);

  localparam bit PARAMS_OK = (DEBOUNCE_CYCLES >= 1) && (HOLD_CYCLES >= 2) &&
                             ((CNT_W > 30) || ((1 << CNT_W) > DEBOUNCE_CYCLES));

  if (!PARAMS_OK) begin : g_bad_params
    $error("switch_debouncer_chan: CNT_W too small or cycle counts out of range");
  end

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_p0;
  logic             sync_p1;
  db_state_e        state;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      state   <= STABLE_LOW;
      cnt     <= '0;
      db      <= 1'b0;
      rise    <= 1'b0;
      fall    <= 1'b0;
    end else begin
      // synchroniser stages p0 -> p1; FSM consumes only sync_p1
      sync_p0 <= sw;
      sync_p1 <= sync_p0;
      rise    <= 1'b0;
      fall    <= 1'b0;
      case (state)
        STABLE_LOW: begin
          if (sync_p1) begin
            state <= CHK_HIGH;
            cnt   <= CNT_W'(1);
          end
        end
        CHK_HIGH: begin
          if (!sync_p1) begin
            state <= STABLE_LOW;
            cnt   <= '0;
          end else if (cnt >= CNT_LAST) begin
            state <= STABLE_HIGH;
            cnt   <= '0;
            db    <= 1'b1;
            rise  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STABLE_HIGH: begin
          if (!sync_p1) begin
            state <= CHK_LOW;
            cnt   <= CNT_W'(1);
          end
        end
        CHK_LOW: begin
          if (sync_p1) begin
            state <= STABLE_HIGH;
            cnt   <= '0;
          end else if (cnt >= CNT_LAST) begin
            state <= STABLE_LOW;
            cnt   <= '0;
            db    <= 1'b0;
            fall  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      endcase
    end
  end

`ifdef LONG_PRESS_EN
  localparam int                HOLD_W    = cnt_width(HOLD_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_SAT  = HOLD_W'(HOLD_CYCLES);

  logic [HOLD_W-1:0] hold_cnt;

  // Counter parks one past HOLD_LAST so the pulse fires exactly once per press.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt   <= '0;
      long_press <= 1'b0;
    end else begin
      long_press <= 1'b0;
      if (state == STABLE_HIGH) begin
        if (hold_cnt != HOLD_SAT) begin
          hold_cnt <= hold_cnt + 1'b1;
        end
        long_press <= (hold_cnt == HOLD_LAST);
      end else begin
        hold_cnt <= '0;
      end
    end
  end
`else
  assign long_press = 1'b0;
`endif

endmodule

// File: rtl/switch_debouncer.sv
// Switch/button conditioner: per-channel debounce plus a single-entry edge event register.
// Optional long-press pulses are built only when LONG_PRESS_EN is defined.
module switch_debouncer
  import switch_debouncer_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_20MS,
  parameter int CNT_W           = 20,
  parameter int HOLD_CYCLES     = HOLD_1S
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [WIDTH-1:0]    sw,
  output logic [WIDTH-1:0]    sw_db,
  output logic [WIDTH-1:0]    sw_rise,
  output logic [WIDTH-1:0]    sw_fall,
  output logic [WIDTH-1:0]    long_press,
  switch_debouncer_if.master  evt
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    switch_debouncer_chan #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W),
      .HOLD_CYCLES     (HOLD_CYCLES)
    ) u_chan (
      .clk        (clk),
      .rst        (rst),
      .sw         (sw[i]),
      .db         (sw_db[i]),
      .rise       (sw_rise[i]),
      .fall       (sw_fall[i]),
      .long_press (long_press[i])
    );
  end

  logic any_edge;
  assign any_edge = (|sw_rise) || (|sw_fall);

  // Stalled events absorb new edges by OR; a consume cycle with a fresh edge reloads
  // instead of clearing so nothing is dropped between events.
  always_ff @(posedge clk) begin
    if (rst) begin
      evt.evt_valid    <= 1'b0;
      evt.evt_rise     <= '0;
      evt.evt_fall     <= '0;
      evt.evt_overflow <= 1'b0;
    end else if (!evt.evt_valid) begin
      if (any_edge) begin
        evt.evt_valid    <= 1'b1;
        evt.evt_rise     <= sw_rise;
        evt.evt_fall     <= sw_fall;
        evt.evt_overflow <= 1'b0;
      end
    end else if (evt.evt_ready) begin
      evt.evt_valid    <= any_edge;
      evt.evt_rise     <= sw_rise;
      evt.evt_fall     <= sw_fall;
      evt.evt_overflow <= 1'b0;
    end else if (any_edge) begin
      evt.evt_rise     <= evt.evt_rise | sw_rise;
      evt.evt_fall     <= evt.evt_fall | sw_fall;
      evt.evt_overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_switch_debouncer.sv
// Scoreboard bench for switch_debouncer with DEBOUNCE_CYCLES=8, HOLD_CYCLES=32; build with
// or without LONG_PRESS_EN, the long-press expectation follows the same macro.
module tb_switch_debouncer;

  localparam int WIDTH = 4;
  localparam int DEB   = 8;
  localparam int CNT_W = 4;
  localparam int HOLD  = 32;

`ifdef LONG_PRESS_EN
  localparam int          LP_TOTAL = 1;
  localparam logic [3:0]  LP_CH2   = 4'b0100;
`else
  localparam int          LP_TOTAL = 0;
  localparam logic [3:0]  LP_CH2   = 4'b0000;
`endif

  typedef struct packed {
    logic [3:0] rise;
    logic [3:0] fall;
    logic       ovf;
  } evt_t;

  typedef struct packed {
    logic [3:0] rise;
    logic [3:0] fall;
  } pulse_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] sw  = 4'b0000;
  logic [3:0] sw_db, sw_rise, sw_fall, long_press;

  switch_debouncer_if #(.WIDTH(WIDTH)) evt_if ();

  switch_debouncer #(
    .WIDTH           (WIDTH),
    .DEBOUNCE_CYCLES (DEB),
    .CNT_W           (CNT_W),
    .HOLD_CYCLES     (HOLD)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sw         (sw),
    .sw_db      (sw_db),
    .sw_rise    (sw_rise),
    .sw_fall    (sw_fall),
    .long_press (long_press),
    .evt        (evt_if)
  );

  always #5 clk = ~clk;

  evt_t   evq[$];
  pulse_t pq[$];
  int     n_chk   = 0;
  int     n_fail  = 0;
  int     lp_seen = 0;
  evt_t   mon_got, mon_exp;
  pulse_t pmon_got, pmon_exp;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic push_evt(input logic [3:0] r, input logic [3:0] f, input logic o);
    evt_t e;
    e.rise = r; e.fall = f; e.ovf = o;
    evq.push_back(e);
  endtask

  task automatic push_pulse(input logic [3:0] r, input logic [3:0] f);
    pulse_t p;
    p.rise = r; p.fall = f;
    pq.push_back(p);
  endtask

  task automatic wait_rise(input string nm, input logic [3:0] mask, input int budget);
    int k = 0;
    while (((sw_rise & mask) == 4'b0000) && (k < budget)) begin
      cyc();
      k++;
    end
    chk(nm, (k < budget), 1);
  endtask

  // Event monitor: every accepted handshake is compared against the scoreboard head.
  always @(negedge clk) begin
    if (!rst && evt_if.evt_valid === 1'b1 && evt_if.evt_ready === 1'b1) begin
      mon_got.rise = evt_if.evt_rise;
      mon_got.fall = evt_if.evt_fall;
      mon_got.ovf  = evt_if.evt_overflow;
      if (evq.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL evt_unexpected: got %h expected none", mon_got);
      end else begin
        mon_exp = evq.pop_front();
        chk("evt_pop", mon_got, mon_exp);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && ((|sw_rise) === 1'b1 || (|sw_fall) === 1'b1)) begin
      pmon_got.rise = sw_rise;
      pmon_got.fall = sw_fall;
      if (pq.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL pulse_unexpected: got %h expected none", pmon_got);
      end else begin
        pmon_exp = pq.pop_front();
        chk("pulse_pop", pmon_got, pmon_exp);
      end
    end
    if (!rst && (|long_press) === 1'b1) lp_seen += $countones(long_press);
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    evt_if.evt_ready = 1'b0;
    cyc(2);
    chk("rst_db", sw_db, 0);
    chk("rst_pulses", {sw_rise, sw_fall}, 0);
    chk("rst_evt", {evt_if.evt_valid, evt_if.evt_rise, evt_if.evt_fall, evt_if.evt_overflow}, 0);
    chk("rst_long_press", long_press, 0);
    rst = 1'b0;

    // T1: clean rise on ch0, 10-cycle latency, event one cycle later
    evt_if.evt_ready = 1'b1;
    push_pulse(4'b0001, 4'b0000);
    push_evt(4'b0001, 4'b0000, 1'b0);
    sw[0] = 1'b1;
    cyc(9);
    chk("t1_db_cycle9", sw_db[0], 0);
    cyc();
    chk("t1_db_cycle10", sw_db[0], 1);
    chk("t1_rise", sw_rise, 4'b0001);
    cyc();
    chk("t1_rise_single", sw_rise, 0);
    chk("t1_evt_valid", evt_if.evt_valid, 1);
    chk("t1_evt_rise", evt_if.evt_rise, 4'b0001);
    cyc();
    chk("t1_evt_consumed", evt_if.evt_valid, 0);

    push_pulse(4'b0000, 4'b0001);
    push_evt(4'b0000, 4'b0001, 1'b0);
    sw[0] = 1'b0;
    cyc(10);
    chk("rel0_db", sw_db, 0);
    chk("rel0_fall", sw_fall, 4'b0001);
    cyc(2);
    chk("rel0_evt_done", evt_if.evt_valid, 0);

    // T2: bouncing ch1 never settles
    sw[1] = 1'b1; cyc(5);
    sw[1] = 1'b0; cyc(1);
    sw[1] = 1'b1; cyc(5);
    sw[1] = 1'b0;
    cyc(14);
    chk("t2_db", sw_db, 0);
    chk("t2_evt_valid", evt_if.evt_valid, 0);

    // T3: stalled consumer merges edges and flags overflow
    evt_if.evt_ready = 1'b0;
    push_pulse(4'b0001, 4'b0000);
    sw[0] = 1'b1;
    cyc(11);
    chk("t3_first_valid", evt_if.evt_valid, 1);
    push_pulse(4'b0100, 4'b0001);
    push_evt(4'b0101, 4'b0001, 1'b1);
    sw[0] = 1'b0;
    sw[2] = 1'b1;
    cyc(10);
    chk("t3_pulses", {sw_rise, sw_fall}, {4'b0100, 4'b0001});
    chk("t3_stall_stable", {evt_if.evt_rise, evt_if.evt_fall, evt_if.evt_overflow}, {4'b0001, 4'b0000, 1'b0});
    cyc();
    chk("t3_merged", {evt_if.evt_rise, evt_if.evt_fall, evt_if.evt_overflow}, {4'b0101, 4'b0001, 1'b1});
    cyc(3);
    chk("t3_merged_hold", {evt_if.evt_valid, evt_if.evt_rise, evt_if.evt_fall, evt_if.evt_overflow},
        {1'b1, 4'b0101, 4'b0001, 1'b1});
    evt_if.evt_ready = 1'b1;
    cyc();
    evt_if.evt_ready = 1'b0;
    chk("t3_drop", {evt_if.evt_valid, evt_if.evt_overflow}, 0);

    // T4: consume and new edge in the same cycle
    push_pulse(4'b0000, 4'b0100);
    push_pulse(4'b1000, 4'b0000);
    push_evt(4'b0000, 4'b0100, 1'b0);
    push_evt(4'b1000, 4'b0000, 1'b0);
    sw[2] = 1'b0;
    cyc(3);
    sw[3] = 1'b1;
    wait_rise("t4_rise3_seen", 4'b1000, 20);
    chk("t4_pending", {evt_if.evt_valid, evt_if.evt_fall}, {1'b1, 4'b0100});
    evt_if.evt_ready = 1'b1;
    cyc();
    chk("t4_reload", {evt_if.evt_valid, evt_if.evt_rise, evt_if.evt_fall, evt_if.evt_overflow},
        {1'b1, 4'b1000, 4'b0000, 1'b0});
    cyc();
    evt_if.evt_ready = 1'b0;
    chk("t4_done", evt_if.evt_valid, 0);

    // T5: reset at cnt=5 of CHK_HIGH discards everything, then held pins re-debounce
    sw[1] = 1'b1;
    cyc(7);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("t5_db_cleared", sw_db, 0);
    chk("t5_no_pulse", {sw_rise, sw_fall}, 0);
    chk("t5_evt_cleared", evt_if.evt_valid, 0);
    push_pulse(4'b1010, 4'b0000);
    push_evt(4'b1010, 4'b0000, 1'b0);
    evt_if.evt_ready = 1'b1;
    cyc(9);
    chk("t5_db_cycle9", sw_db, 0);
    cyc();
    chk("t5_db_cycle10", sw_db, 4'b1010);
    chk("t5_rise", sw_rise, 4'b1010);
    cyc(2);
    chk("t5_evt_done", evt_if.evt_valid, 0);

    // T6: long press on ch2
    push_pulse(4'b0000, 4'b1010);
    push_evt(4'b0000, 4'b1010, 1'b0);
    sw[1] = 1'b0;
    sw[3] = 1'b0;
    cyc(12);
    push_pulse(4'b0100, 4'b0000);
    push_evt(4'b0100, 4'b0000, 1'b0);
    sw[2] = 1'b1;
    cyc(10);
    chk("t6_rise", sw_rise, 4'b0100);
    cyc(31);
    chk("t6_lp_before", long_press, 0);
    cyc();
    chk("t6_lp_at32", long_press, LP_CH2);
    cyc();
    chk("t6_lp_after", long_press, 0);
    cyc(40);
    push_pulse(4'b0000, 4'b0100);
    push_evt(4'b0000, 4'b0100, 1'b0);
    sw[2] = 1'b0;
    cyc(14);
    chk("t6_lp_total", lp_seen, LP_TOTAL);
    chk("end_evq_empty", evq.size(), 0);
    chk("end_pq_empty", pq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
